// File: rtl/power_switch_sequencer.sv
// Staged power-switch sequencer for one switchable domain.
// Ramps the header switch stages on one at a time, waits for supply-good,
// then removes isolation. On power-down it isolates first and ramps the
// stages off in reverse order. A missing supply-good within TIMEOUT cycles
// parks the block in ERR with every stage off.
//
// All outputs are flops. They are loaded from the next-state decode, so
// each output changes on the same edge as the state transition that
// implies it.
//
// The stage vector is always a thermometer code (bits 0..n set).
// "Add next stage" is therefore a left shift with 1 inserted, and
// "clear highest stage" is a right shift.
module power_switch_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwr_req,
  input  logic [7:0]            stage_dly,
  input  logic                  pwr_good,
  output logic [NUM_STAGES-1:0] sleep_n_stages,
  output logic                  iso_en,
  output logic                  pwr_ack,
  output logic                  err,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_SETTLE    = 3'd2,
    S_ON        = 3'd3,
    S_ISO       = 3'd4,
    S_RAMP_DOWN = 3'd5,
    S_ERR       = 3'd6,
    S_UNUSED    = 3'd7
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t                r_state, w_state_nxt;
  logic [NUM_STAGES-1:0] r_stages, w_stages_nxt;
  logic [7:0]            r_dly_cnt, w_dly_cnt_nxt;
  logic [15:0]           r_to_cnt, w_to_cnt_nxt;
  logic                  r_iso, r_ack, r_err;
  logic [NUM_STAGES-1:0] w_stages_up, w_stages_dn, w_stage_first;

  assign w_stages_up    = {r_stages[NUM_STAGES-2:0], 1'b1};
  assign w_stages_dn    = {1'b0, r_stages[NUM_STAGES-1:1]};
  assign w_stage_first  = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  assign state          = r_state;
  assign sleep_n_stages = r_stages;
  assign iso_en         = r_iso;
  assign pwr_ack        = r_ack;
  assign err            = r_err;

  // Register stage: state, stage vector, counters and the decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OFF;
      r_stages  <= '0;
      r_dly_cnt <= '0;
      r_to_cnt  <= '0;
      r_iso     <= 1'b1;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stages  <= w_stages_nxt;
      r_dly_cnt <= w_dly_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_iso     <= (w_state_nxt != S_ON);
      r_ack     <= (w_state_nxt == S_ON);
      r_err     <= (w_state_nxt == S_ERR);
    end
  end

  // Next-state logic: sequencing, stage stepping and counter updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_stages_nxt  = r_stages;
    w_dly_cnt_nxt = r_dly_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    case (r_state)
      S_OFF: begin
        w_stages_nxt = '0;
        if (pwr_req) begin
          w_state_nxt   = S_RAMP_UP;
          w_stages_nxt  = w_stage_first;
          w_dly_cnt_nxt = stage_dly;
        end
      end
      S_RAMP_UP: begin
        if (!pwr_req) begin
          // Abort: isolation is already on, so start the ramp-down at once.
          w_stages_nxt  = w_stages_dn;
          w_dly_cnt_nxt = stage_dly;
          w_state_nxt   = (w_stages_dn == '0) ? S_OFF : S_RAMP_DOWN;
        end else if (r_dly_cnt == 8'd0) begin
          if (r_stages[NUM_STAGES-1]) begin
            w_state_nxt  = S_SETTLE;
            w_to_cnt_nxt = '0;
          end else begin
            w_stages_nxt  = w_stages_up;
            w_dly_cnt_nxt = stage_dly;
          end
        end else begin
          w_dly_cnt_nxt = r_dly_cnt - 8'd1;
        end
      end
      S_SETTLE: begin
        if (!pwr_req) begin
          w_stages_nxt  = w_stages_dn;
          w_dly_cnt_nxt = stage_dly;
          w_state_nxt   = (w_stages_dn == '0) ? S_OFF : S_RAMP_DOWN;
        end else if (pwr_good) begin
          w_state_nxt = S_ON;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt  = S_ERR;
          w_stages_nxt = '0;
          w_to_cnt_nxt = '0;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 16'd1;
        end
      end
      S_ON: begin
        // A supply-good drop here is deliberately ignored.
        if (!pwr_req) w_state_nxt = S_ISO;
      end
      S_ISO: begin
        w_stages_nxt  = w_stages_dn;
        w_dly_cnt_nxt = stage_dly;
        w_state_nxt   = (w_stages_dn == '0) ? S_OFF : S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        // A new request is ignored until the domain is fully off.
        if (r_dly_cnt == 8'd0) begin
          w_stages_nxt  = w_stages_dn;
          w_dly_cnt_nxt = stage_dly;
          if (w_stages_dn == '0) w_state_nxt = S_OFF;
        end else begin
          w_dly_cnt_nxt = r_dly_cnt - 8'd1;
        end
      end
      S_ERR: begin
        w_stages_nxt = '0;
        if (!pwr_req) w_state_nxt = S_OFF;
      end
      default: begin
        w_state_nxt  = S_ERR;
        w_stages_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Bench for power_switch_sequencer. The reference model tracks the number of
// stages that are on and absolute cycle deadlines. A driver pushes the
// expected output vector for every clock edge. A monitor on the falling edge
// pops each expected vector and compares it with the DUT outputs.
module tb_power_switch_sequencer;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int W  = 3 + N + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pwr_req = 1'b0;
  logic [7:0]   stage_dly = 8'd0;
  logic         pwr_good = 1'b0;
  logic [N-1:0] sleep_n_stages;
  logic         iso_en, pwr_ack, err;
  logic [2:0]   state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  power_switch_sequencer #(.NUM_STAGES(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .stage_dly(stage_dly),
    .pwr_good(pwr_good), .sleep_n_stages(sleep_n_stages), .iso_en(iso_en),
    .pwr_ack(pwr_ack), .err(err), .state(state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Reference model: phase code, count of stages on, and absolute deadlines
  int     m_phase, m_level;
  longint m_cyc, m_next_at, m_deadline;

  function automatic void model_reset();
    m_phase = 0; m_level = 0; m_cyc = 0; m_next_at = 0; m_deadline = 0;
  endfunction

  function automatic void model_drop(input int dly);
    m_level   = m_level - 1;
    m_next_at = m_cyc + dly + 1;
    m_phase   = (m_level == 0) ? 0 : 5;
  endfunction

  function automatic void model_step(input logic req, input int dly, input logic good);
    m_cyc++;
    case (m_phase)
      0: if (req) begin m_phase = 1; m_level = 1; m_next_at = m_cyc + dly + 1; end
      1: begin
        if (!req) model_drop(dly);
        else if (m_cyc == m_next_at) begin
          if (m_level == N) begin m_phase = 2; m_deadline = m_cyc + TO; end
          else begin m_level++; m_next_at = m_cyc + dly + 1; end
        end
      end
      2: begin
        if (!req) model_drop(dly);
        else if (good) m_phase = 3;
        else if (m_cyc == m_deadline) begin m_phase = 6; m_level = 0; end
      end
      3: if (!req) m_phase = 4;
      4: model_drop(dly);
      5: if (m_cyc == m_next_at) begin
           m_level--;
           m_next_at = m_cyc + dly + 1;
           if (m_level == 0) m_phase = 0;
         end
      6: if (!req) m_phase = 0;
      default: m_phase = 6;
    endcase
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [N-1:0] st;
    int therm;
    therm = (1 << m_level) - 1;
    st = therm[N-1:0];
    return {3'(m_phase), st, (m_phase != 3), (m_phase == 3), (m_phase == 6)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (state,stages,iso,ack,err)", name, act, exp);
    end
  endtask

  // Driver: apply inputs, take one edge, push the expected outputs
  task automatic tick(input logic req, input logic [7:0] dly, input logic good);
    pwr_req = req; stage_dly = dly; pwr_good = good;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(req, int'(dly), good);
      exp_q.push_back(model_vec());
    end
    #1;
  endtask

  task automatic run(input logic req, input logic [7:0] dly, input logic good, input int n);
    for (int i = 0; i < n; i++) tick(req, dly, good);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("outputs", {state, sleep_n_stages, iso_en, pwr_ack, err}, e);
    end
  end

  logic [W-1:0] reset_vec;

  initial begin
    model_reset();
    reset_vec = {3'd0, {N{1'b0}}, 1'b1, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", {state, sleep_n_stages, iso_en, pwr_ack, err}, reset_vec);
    rst_n = 1'b1;

    // Full power-up with spacing 2, supply-good arriving after the ramp
    run(0, 8'd2, 0, 3);
    run(1, 8'd2, 0, 12);
    run(1, 8'd2, 1, 3);
    // Power-down with spacing 1
    run(0, 8'd1, 1, 10);
    // Settle timeout, then recovery through a request drop
    run(1, 8'd0, 0, 16);
    run(0, 8'd0, 0, 3);
    // Abort after two stages, with a request pulse during ramp-down
    run(1, 8'd3, 0, 5);
    run(0, 8'd3, 0, 2);
    run(1, 8'd3, 0, 1);
    run(0, 8'd3, 0, 6);
    // Zero spacing, both directions
    run(1, 8'd0, 1, 8);
    run(0, 8'd0, 1, 8);

    // Asynchronous reset in the middle of a ramp-up
    run(1, 8'd3, 0, 6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {state, sleep_n_stages, iso_en, pwr_ack, err}, reset_vec);
    model_reset();
    run(1, 8'd3, 0, 2);
    rst_n = 1'b1;
    run(1, 8'd1, 1, 14);
    run(0, 8'd1, 1, 10);

    // Randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      int good_pct, len, dmax;
      logic req;
      good_pct = $urandom_range(0, 100);
      len      = $urandom_range(40, 120);
      dmax     = ($urandom_range(0, 3) == 0) ? 6 : 2;
      req      = $urandom_range(0, 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 11) == 0) req = ~req;
        tick(req, 8'($urandom_range(0, dmax)), ($urandom_range(0, 99) < good_pct));
      end
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
